// File: rtl/maint_button_conditioner.sv
// Maintenance push-button conditioner: synchronizer, debounce filter, press-edge detect and
// toggle FSM with a minimum dwell before a press may leave maintenance. Fault forces maintenance.
`timescale 1ns / 1ps

module maint_button_conditioner #(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned MIN_MAINT_MS    = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic fault,
    output logic maint,
    output logic btn_level,
    output logic maint_enter,
    output logic maint_exit
);

    localparam int unsigned DbRaw = CLOCK_FREQUENCY / 1000 * DEBOUNCE_MS;
    localparam int unsigned Db    = (DbRaw == 0) ? 1 : DbRaw;
    localparam int unsigned MdRaw = CLOCK_FREQUENCY / 1000 * MIN_MAINT_MS;
    localparam int unsigned Md    = (MdRaw == 0) ? 1 : MdRaw;
    localparam int unsigned DbW   = $clog2(Db) + 1;
    localparam int unsigned MdW   = $clog2(Md) + 1;

    localparam logic [DbW-1:0] DbLast = DbW'(Db - 1);
    localparam logic [MdW-1:0] MdLast = MdW'(Md - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHold  = 2'd1,
        StMaint = 2'd2
    } state_e;

    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic           level_q, level_d;
    logic           level_dly_q, level_dly_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           press_q, press_d;
    state_e         state_q, state_d;
    logic [MdW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic           maint_q, maint_d;
    logic           maint_dly_q, maint_dly_d;
    logic           enter_q, enter_d;
    logic           exit_q, exit_d;

    // Synchronizer and press-edge detection.
    always_comb begin
        s1_d        = btn_raw;
        s2_d        = s1_q;
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
    end

    // Debounce: the counter only runs while the synchronized input disagrees with the accepted
    // level, so any reversion discards the accumulated time.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DbLast) begin
                level_d  = s2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    // Fault overrides any press and restarts the dwell every cycle it is asserted.
    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        if (fault) begin
            state_d     = StHold;
            dwell_cnt_d = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (press_q) begin
                        state_d     = StHold;
                        dwell_cnt_d = '0;
                    end
                end
                StHold: begin
                    if (dwell_cnt_q == MdLast) begin
                        state_d     = StMaint;
                        dwell_cnt_d = '0;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + MdW'(1);
                    end
                end
                StMaint: begin
                    if (press_q) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d     = StRun;
                    dwell_cnt_d = '0;
                end
            endcase
        end
    end

    // maint follows the next-state decode so it moves on the same edge as the state.
    always_comb begin
        maint_d     = (state_d != StRun);
        maint_dly_d = maint_q;
        enter_d     = maint_q & ~maint_dly_q;
        exit_d      = ~maint_q & maint_dly_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            db_cnt_q    <= '0;
            press_q     <= 1'b0;
            state_q     <= StRun;
            dwell_cnt_q <= '0;
            maint_q     <= 1'b0;
            maint_dly_q <= 1'b0;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            maint_q     <= maint_d;
            maint_dly_q <= maint_dly_d;
            enter_q     <= enter_d;
            exit_q      <= exit_d;
        end
    end

    assign maint       = maint_q;
    assign btn_level   = level_q;
    assign maint_enter = enter_q;
    assign maint_exit  = exit_q;

endmodule

// File: tb/tb_maint_button_conditioner.sv
// Scoreboard bench: stimulus queues expected output events (cycle, kind); a negedge monitor
// turns every observed output change or pulse into an event and matches it against the queue.
`timescale 1ns / 1ps

module tb_maint_button_conditioner;

    localparam int KLevelRise = 0;
    localparam int KLevelFall = 1;
    localparam int KMaintRise = 2;
    localparam int KMaintFall = 3;
    localparam int KEnter     = 4;
    localparam int KExit      = 5;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic fault = 1'b0;
    logic maint, btn_level, maint_enter, maint_exit;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    logic prev_level = 1'b0;
    logic prev_maint = 1'b0;

    maint_button_conditioner #(
        .CLOCK_FREQUENCY(1000),
        .DEBOUNCE_MS    (4),
        .MIN_MAINT_MS   (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .fault      (fault),
        .maint      (maint),
        .btn_level  (btn_level),
        .maint_enter(maint_enter),
        .maint_exit (maint_exit)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            KLevelRise: kname = "btn_level_rise";
            KLevelFall: kname = "btn_level_fall";
            KMaintRise: kname = "maint_rise";
            KMaintFall: kname = "maint_fall";
            KEnter:     kname = "maint_enter";
            default:    kname = "maint_exit";
        endcase
    endfunction

    function automatic logic [63:0] tapw(input int o, input int h);
        logic [63:0] one;
        one  = 64'd1;
        tapw = ((one << h) - one) << o;
    endfunction

    // Keep the queue sorted by (cycle, kind) so pushes may arrive in any order.
    task automatic push(input int c, input int k);
        ev_t e;
        int  idx;
        e.cyc  = c;
        e.kind = k;
        idx    = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > c || (exp_q[i].cyc == c && exp_q[i].kind > k)) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endtask

    // A tap of h cycles first sampled at edge n+o: level rises 5 edges later, falls 5 after release.
    task automatic push_tap(input int n, input int o, input int h);
        push(n + o + 5, KLevelRise);
        push(n + o + h + 5, KLevelFall);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    // Bit k of each pattern is sampled by the DUT at edge n+k, where n = cyc+1 on entry.
    task automatic play(input int len, input logic [63:0] bp, input logic [63:0] fp);
        for (int k = 0; k < len; k++) begin
            btn_raw = bp[k];
            fault   = fp[k];
            @(negedge clock);
        end
        btn_raw = 1'b0;
        fault   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor
    initial begin
        logic [5:0] obs;
        forever begin
            @(negedge clock);
            if (!reset) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing %s: required at cycle %0d, still absent at cycle %0d",
                             kname(exp_q[0].kind), exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
                obs[KLevelRise] = btn_level & ~prev_level;
                obs[KLevelFall] = ~btn_level & prev_level;
                obs[KMaintRise] = maint & ~prev_maint;
                obs[KMaintFall] = ~maint & prev_maint;
                obs[KEnter]     = maint_enter;
                obs[KExit]      = maint_exit;
                for (int k = 0; k < 6; k++) begin
                    if (obs[k]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected %s at cycle %0d: required no event",
                                     kname(k), cyc);
                        end else if (exp_q[0].cyc != cyc || exp_q[0].kind != k) begin
                            errors++;
                            $display("FAIL event %s at cycle %0d: required %s at cycle %0d",
                                     kname(k), cyc, kname(exp_q[0].kind), exp_q[0].cyc);
                        end else begin
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
            prev_level = btn_level;
            prev_maint = maint;
        end
    end

    initial begin
        int          n;
        logic [63:0] bp;
        logic [63:0] fp;

        repeat (3) @(negedge clock);
        check("reset_maint", maint, 1'b0);
        check("reset_btn_level", btn_level, 1'b0);
        check("reset_maint_enter", maint_enter, 1'b0);
        check("reset_maint_exit", maint_exit, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Clean press held 20 cycles.
        do_reset();
        repeat (3) @(negedge clock);
        n = cyc + 1;
        push_tap(n, 0, 20);
        push(n + 7, KMaintRise);
        push(n + 8, KEnter);
        play(30, tapw(0, 20), 64'd0);

        // Bounce 1-1-1-0 never reaches the debounce threshold.
        do_reset();
        bp = 64'd0;
        for (int k = 0; k < 50; k++) bp[k] = ((k % 4) != 3);
        play(60, bp, 64'd0);
        check("bounce_btn_level", btn_level, 1'b0);
        check("bounce_maint", maint, 1'b0);

        // Dwell lock: press consumed at n+15 lands in HOLD (ignored); press at n+23 exits.
        do_reset();
        n = cyc + 1;
        push_tap(n, 0, 4);
        push_tap(n, 8, 4);
        push_tap(n, 16, 4);
        push(n + 7, KMaintRise);
        push(n + 8, KEnter);
        push(n + 23, KMaintFall);
        push(n + 24, KExit);
        play(32, tapw(0, 4) | tapw(8, 4) | tapw(16, 4), 64'd0);

        // Fault priority: fault at n+7..n+9 with a simultaneous press; press at n+19 is the
        // last HOLD edge; fault at n+27 beats a press in MAINT; press at n+43 finally exits.
        do_reset();
        n  = cyc + 1;
        bp = tapw(0, 4) | tapw(12, 4) | tapw(20, 4) | tapw(28, 4) | tapw(36, 4);
        fp = tapw(7, 3) | tapw(27, 1);
        push_tap(n, 0, 4);
        push_tap(n, 12, 4);
        push_tap(n, 20, 4);
        push_tap(n, 28, 4);
        push_tap(n, 36, 4);
        push(n + 7, KMaintRise);
        push(n + 8, KEnter);
        push(n + 43, KMaintFall);
        push(n + 44, KExit);
        play(52, bp, fp);

        // Async reset in the middle of HOLD.
        do_reset();
        n = cyc + 1;
        push_tap(n, 0, 4);
        push(n + 7, KMaintRise);
        push(n + 8, KEnter);
        play(11, tapw(0, 4), 64'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_maint", maint, 1'b0);
        check("async_reset_maint_exit", maint_exit, 1'b0);
        check("async_reset_maint_enter", maint_enter, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        play(20, 64'd0, 64'd0);
        check("after_reset_maint", maint, 1'b0);

        // Button held through reset release.
        btn_raw = 1'b1;
        do_reset();
        n = cyc + 1;
        push_tap(n, 0, 10);
        push(n + 7, KMaintRise);
        push(n + 8, KEnter);
        play(30, tapw(0, 10), 64'd0);
        check("held_reset_maint", maint, 1'b1);

        repeat (5) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d events outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
